// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-cache memory arbiter: FSM state codes and
// memory operation encoding.
package mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  // Evict must precede fill, so a pending write always wins within a client.
  function automatic logic sel_op(input logic write_req);
    return write_req ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin picker: grants ptr on contention, otherwise the sole requester.
// Purely combinational; the pointer register lives in the caller.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      gnt = ptr;
    end else begin
      gnt = req[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises D-cache (client 0) and I-cache (client 1) evict/fill requests onto
// one memory port, one transaction at a time, round-robin between clients.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c0_write_req,
  input  logic [31:0]      c0_write_addr,
  input  logic [WIDTH-1:0] c0_write_data,
  output logic             c0_write_ack,
  input  logic             c0_read_req,
  input  logic [31:0]      c0_read_addr,
  output logic [WIDTH-1:0] c0_read_data,
  output logic             c0_read_ack,
  input  logic             c1_write_req,
  input  logic [31:0]      c1_write_addr,
  input  logic [WIDTH-1:0] c1_write_data,
  output logic             c1_write_ack,
  input  logic             c1_read_req,
  input  logic [31:0]      c1_read_addr,
  output logic [WIDTH-1:0] c1_read_data,
  output logic             c1_read_ack,
  output logic             mem_req,
  output logic             mem_rw,
  output logic [31:0]      mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             busy
);

  arb_state_t       state, state_nxt;
  logic             rr_ptr, rr_nxt;
  logic             gnt_q, gnt_nxt;
  logic             req_nxt, rw_nxt, busy_nxt;
  logic [31:0]      addr_nxt;
  logic [WIDTH-1:0] wdata_nxt;

  logic [1:0]       pending;
  logic             pick_gnt, pick_vld, pick_op;
  logic             done;

  assign pending = {c1_write_req | c1_read_req, c0_write_req | c0_read_req};

  arb_rr2 u_rr (
    .req   (pending),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .valid (pick_vld)
  );

  assign pick_op = pick_gnt ? sel_op(c1_write_req) : sel_op(c0_write_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      rr_ptr    <= 1'b0;
      gnt_q     <= 1'b0;
      mem_req   <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      gnt_q     <= gnt_nxt;
      mem_req   <= req_nxt;
      mem_rw    <= rw_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    gnt_nxt   = gnt_q;
    req_nxt   = mem_req;
    rw_nxt    = mem_rw;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    busy_nxt  = busy;
    case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_nxt = ARB_BUSY;
          gnt_nxt   = pick_gnt;
          rr_nxt    = ~pick_gnt;
          req_nxt   = 1'b1;
          busy_nxt  = 1'b1;
          rw_nxt    = pick_op;
          wdata_nxt = pick_gnt ? c1_write_data : c0_write_data;
          if (pick_gnt) begin
            addr_nxt = (pick_op == OP_WRITE) ? c1_write_addr : c1_read_addr;
          end else begin
            addr_nxt = (pick_op == OP_WRITE) ? c0_write_addr : c0_read_addr;
          end
        end
      end
      ARB_BUSY: begin
        // Completion returns to IDLE; new requests wait for the following edge.
        if (mem_ack) begin
          state_nxt = ARB_IDLE;
          req_nxt   = 1'b0;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign done         = (state == ARB_BUSY) && mem_ack;
  assign c0_write_ack = done && !gnt_q && (mem_rw == OP_WRITE);
  assign c0_read_ack  = done && !gnt_q && (mem_rw == OP_READ);
  assign c1_write_ack = done &&  gnt_q && (mem_rw == OP_WRITE);
  assign c1_read_ack  = done &&  gnt_q && (mem_rw == OP_READ);

  assign c0_read_data = mem_rdata;
  assign c1_read_data = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, op priority, ack steering, reset abort.
module tb_mem_arbiter;

  localparam int WIDTH = 128;

  logic             clk = 1'b0;
  logic             reset;
  logic             c0_write_req, c0_read_req, c1_write_req, c1_read_req;
  logic [31:0]      c0_write_addr, c0_read_addr, c1_write_addr, c1_read_addr;
  logic [WIDTH-1:0] c0_write_data, c1_write_data;
  logic             c0_write_ack, c0_read_ack, c1_write_ack, c1_read_ack;
  logic [WIDTH-1:0] c0_read_data, c1_read_data;
  logic             mem_req, mem_rw, mem_ack, busy;
  logic [31:0]      mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .c0_write_req  (c0_write_req),
    .c0_write_addr (c0_write_addr),
    .c0_write_data (c0_write_data),
    .c0_write_ack  (c0_write_ack),
    .c0_read_req   (c0_read_req),
    .c0_read_addr  (c0_read_addr),
    .c0_read_data  (c0_read_data),
    .c0_read_ack   (c0_read_ack),
    .c1_write_req  (c1_write_req),
    .c1_write_addr (c1_write_addr),
    .c1_write_data (c1_write_data),
    .c1_write_ack  (c1_write_ack),
    .c1_read_req   (c1_read_req),
    .c1_read_addr  (c1_read_addr),
    .c1_read_data  (c1_read_data),
    .c1_read_ack   (c1_read_ack),
    .mem_req       (mem_req),
    .mem_rw        (mem_rw),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic acks(input string tag, input logic [3:0] exp);
    chk(tag, {124'd0, c0_write_ack, c0_read_ack, c1_write_ack, c1_read_ack}, {124'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    c0_write_req = 0; c0_read_req = 0; c1_write_req = 0; c1_read_req = 0;
    c0_write_addr = 0; c0_read_addr = 0; c1_write_addr = 0; c1_read_addr = 0;
    c0_write_data = 0; c1_write_data = 0;
    mem_ack = 0; mem_rdata = 0;
    step(); step();
    reset = 1'b0;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rw", mem_rw, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    // 1: lone c0 read
    c0_read_req = 1; c0_read_addr = 32'h100;
    step();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_rw", mem_rw, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_busy", busy, 1);
    mem_rdata = {16{8'hAA}}; mem_ack = 1; #1;
    acks("t1_acks", 4'b0100);
    chk("t1_c0_rdata", c0_read_data, {16{8'hAA}});
    step();
    mem_ack = 0; c0_read_req = 0;
    chk("t1_done_req", mem_req, 0);
    chk("t1_done_busy", busy, 0);

    // 2: c0 write and read together -> write first (rr_ptr now 1, only c0 pending)
    c0_write_req = 1; c0_write_addr = 32'h200; c0_write_data = 128'h1234;
    c0_read_req = 1; c0_read_addr = 32'h300;
    step();
    chk("t2_w_rw", mem_rw, 0);
    chk("t2_w_addr", mem_addr, 32'h200);
    chk("t2_w_wdata", mem_wdata, 128'h1234);
    mem_ack = 1; #1;
    acks("t2_w_acks", 4'b1000);
    step();
    mem_ack = 0; c0_write_req = 0;
    chk("t2_gap_req", mem_req, 0);
    step();
    chk("t2_r_req", mem_req, 1);
    chk("t2_r_rw", mem_rw, 1);
    chk("t2_r_addr", mem_addr, 32'h300);
    mem_rdata = 128'h55; mem_ack = 1; #1;
    acks("t2_r_acks", 4'b0100);
    step();
    mem_ack = 0; c0_read_req = 0;

    // 3: contention after reset alternates 0,1,0,1
    reset = 1; step(); reset = 0;
    c0_read_req = 1; c0_read_addr = 32'h10;
    c1_read_req = 1; c1_read_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t3_addr%0d", i), mem_addr, (i % 2 == 0) ? 32'h10 : 32'h20);
      mem_ack = 1; #1;
      acks($sformatf("t3_acks%0d", i), (i % 2 == 0) ? 4'b0100 : 4'b0001);
      step();
      mem_ack = 0;
      chk($sformatf("t3_gap%0d", i), mem_req, 0);
    end
    c0_read_req = 0; c1_read_req = 0;

    // 4: stray mem_ack while idle
    step();
    mem_ack = 1; #1;
    acks("t4_acks", 4'b0000);
    step();
    mem_ack = 0;
    chk("t4_req", mem_req, 0);
    chk("t4_busy", busy, 0);

    // 5: reset mid-BUSY aborts; later mem_ack ignored; c0 wins next contention
    c1_read_req = 1; c1_read_addr = 32'h40;
    step();
    chk("t5_busy_before", busy, 1);
    reset = 1; c1_read_req = 0;
    step();
    reset = 0;
    chk("t5_req_after", mem_req, 0);
    chk("t5_busy_after", busy, 0);
    step();
    mem_ack = 1; #1;
    acks("t5_stray_acks", 4'b0000);
    step();
    mem_ack = 0;
    c0_read_req = 1; c0_read_addr = 32'h44;
    c1_read_req = 1; c1_read_addr = 32'h48;
    step();
    chk("t5_first_gnt", mem_addr, 32'h44);
    mem_ack = 1; #1;
    acks("t5_c0_ack", 4'b0100);
    step();
    mem_ack = 0; c0_read_req = 0; c1_read_req = 0;

    // 6: address change while BUSY is ignored
    c1_read_req = 1; c1_read_addr = 32'h400;
    step();
    chk("t6_addr0", mem_addr, 32'h400);
    c1_read_addr = 32'h500;
    step();
    chk("t6_addr1", mem_addr, 32'h400);
    step();
    chk("t6_addr2", mem_addr, 32'h400);
    mem_rdata = 128'hC0FFEE; mem_ack = 1; #1;
    acks("t6_acks", 4'b0001);
    chk("t6_c1_rdata", c1_read_data, 128'hC0FFEE);
    step();
    mem_ack = 0; c1_read_req = 0;

    // c1 evict
    step();
    c1_write_req = 1; c1_write_addr = 32'h600; c1_write_data = 128'hBEEF;
    step();
    chk("t7_rw", mem_rw, 0);
    chk("t7_addr", mem_addr, 32'h600);
    chk("t7_wdata", mem_wdata, 128'hBEEF);
    mem_ack = 1; #1;
    acks("t7_acks", 4'b0010);
    step();
    mem_ack = 0; c1_write_req = 0;
    chk("t7_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
